// File: rtl/sprite_blitter_pkg.sv
// Shared sprite/screen geometry, pixel word layout and blitter state encodings.
package sprite_defs;
  localparam int SPR_W     = 28;
  localparam int SPR_H     = 30;
  localparam int SPR_WORDS = 840;
  localparam int SCR_W     = 160;
  localparam int SCR_H     = 120;

  localparam int ADDR_W = 10;
  localparam int COL_W  = 5;
  localparam int ROW_W  = 5;

  localparam int PIX_OPAQUE  = 0;
  localparam int PIX_COL_LSB = 1;
  localparam int PIX_COL_MSB = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sprite_blitter_scan_counter.sv
// Raster scan counter over the sprite ROM: linear address plus column/row with
// column wrap and a flag marking the last pixel of the sprite.
module sprite_scan_counter #(
  parameter int SPR_W = sprite_defs::SPR_W,
  parameter int SPR_H = sprite_defs::SPR_H
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          advance,
  output logic [sprite_defs::ADDR_W-1:0] addr,
  output logic [sprite_defs::COL_W-1:0]  col,
  output logic [sprite_defs::ROW_W-1:0]  row,
  output logic                          last
);
  import sprite_defs::ADDR_W;
  import sprite_defs::COL_W;
  import sprite_defs::ROW_W;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;

  assign last = (addr_q == ADDR_W'(SPR_W * SPR_H - 1));

  // Stepping past the last pixel returns to zero so addr never leaves the ROM.
  always_comb begin
    addr_d = addr_q;
    col_d  = col_q;
    row_d  = row_q;
    if (clear) begin
      addr_d = '0;
      col_d  = '0;
      row_d  = '0;
    end else if (advance) begin
      if (last) begin
        addr_d = '0;
        col_d  = '0;
        row_d  = '0;
      end else begin
        addr_d = addr_q + 1'b1;
        if (col_q == COL_W'(SPR_W - 1)) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      addr_q <= addr_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end

  assign addr = addr_q;
  assign col  = col_q;
  assign row  = row_q;
endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: scans the sprite ROM once per go, clips against the screen and
// emits registered VGA plot requests for opaque on-screen pixels.
module sprite_blitter #(
  parameter int SPR_W = sprite_defs::SPR_W,
  parameter int SPR_H = sprite_defs::SPR_H,
  parameter int SCR_W = sprite_defs::SCR_W,
  parameter int SCR_H = sprite_defs::SCR_H
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [7:0]  x_origin,
  input  logic [6:0]  y_origin,
  output logic [9:0]  addr_read,
  input  logic [15:0] pix_in,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [14:0] vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        done
);
  import sprite_defs::state_t;
  import sprite_defs::ST_IDLE;
  import sprite_defs::ST_DRAW;
  import sprite_defs::ST_DONE;
  import sprite_defs::COL_W;
  import sprite_defs::ROW_W;
  import sprite_defs::PIX_OPAQUE;
  import sprite_defs::PIX_COL_LSB;
  import sprite_defs::PIX_COL_MSB;

  state_t state_q, state_d;
  logic [7:0]  x0_q, x0_d;
  logic [6:0]  y0_q, y0_d;
  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic [14:0] vga_colour_q, vga_colour_d;
  logic        vga_plot_q, vga_plot_d;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last;
  logic [8:0]       x_sum;
  logic [7:0]       y_sum;
  logic             on_screen;

  sprite_scan_counter #(
    .SPR_W(SPR_W),
    .SPR_H(SPR_H)
  ) u_scan (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state_q == ST_IDLE) && go),
    .advance(state_q == ST_DRAW),
    .addr   (addr_read),
    .col    (col),
    .row    (row),
    .last   (last)
  );

  // One extra bit of headroom so positions past the screen edge clip instead of wrapping.
  assign x_sum     = {1'b0, x0_q} + 9'(col);
  assign y_sum     = {1'b0, y0_q} + 8'(row);
  assign on_screen = (x_sum < 9'(SCR_W)) && (y_sum < 8'(SCR_H));

  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          x0_d    = x_origin;
          y0_d    = y_origin;
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        vga_x_d      = x_sum[7:0];
        vga_y_d      = y_sum[6:0];
        vga_colour_d = pix_in[PIX_COL_MSB:PIX_COL_LSB];
        vga_plot_d   = pix_in[PIX_OPAQUE] && on_screen;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a behavioural ROM feeds the DUT, expected
// plots are queued per draw and popped as the DUT raises vga_plot.
module tb_sprite_blitter;
  import sprite_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [7:0]  x_origin;
  logic [6:0]  y_origin;
  logic [9:0]  addr_read;
  logic [15:0] pix_in;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [14:0] vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int rom_mode = 0;
  int plot_count = 0;
  int done_count = 0;
  int cyc;
  logic [29:0] exp_q[$];
  logic [14:0] seen_q[$];
  logic [29:0] exp_v;

  sprite_blitter dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .x_origin  (x_origin),
    .y_origin  (y_origin),
    .addr_read (addr_read),
    .pix_in    (pix_in),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Mode 0: every word opaque; mode 1: even words transparent, odd words opaque.
  function automatic logic [15:0] romWord(input int mode, input int a);
    int  c;
    logic opq;
    c   = (a * 7919 + mode * 123 + 17) & 32'h7fff;
    opq = (mode == 0) || (a % 2 == 1);
    return {c[14:0], opq};
  endfunction

  assign pix_in = romWord(rom_mode, int'(addr_read));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int mode, input int x0, input int y0);
    logic [15:0] w;
    int xs, ys;
    rom_mode = mode;
    for (int a = 0; a < SPR_W * SPR_H; a++) begin
      w  = romWord(mode, a);
      xs = x0 + a % SPR_W;
      ys = y0 + a / SPR_W;
      if (w[0] && xs < SCR_W && ys < SCR_H)
        exp_q.push_back({xs[7:0], ys[6:0], w[15:1]});
    end
  endtask

  task automatic clearStats();
    plot_count = 0;
    done_count = 0;
    seen_q.delete();
  endtask

  // Returns in cycle k+1 with junk on the origin inputs, which the DUT must ignore.
  task automatic startDraw(input logic [7:0] x, input logic [6:0] y);
    @(negedge clk);
    x_origin = x;
    y_origin = y;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    x_origin = 8'($urandom);
    y_origin = 7'($urandom);
  endtask

  task automatic waitDone(input int start, input int limit, output int c);
    c = start;
    while (done !== 1'b1 && c < limit) begin
      @(negedge clk);
      c++;
    end
    if (done !== 1'b1) checkOutput("done_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
    if (vga_plot === 1'b1) begin
      plot_count++;
      seen_q.push_back({vga_x, vga_y});
      if (exp_q.size() == 0) begin
        checkOutput("extra_plot", 1, 0);
      end else begin
        exp_v = exp_q.pop_front();
        checkOutput("plot_pixel", {2'b0, vga_x, vga_y, vga_colour}, {2'b0, exp_v});
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    go = 1'b0;
    x_origin = '0;
    y_origin = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_plot", vga_plot, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_addr", addr_read, 0);
    checkOutput("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
    reset = 1'b0;

    // Opaque sprite at (10,20)
    clearStats();
    applyStimulus(0, 10, 20);
    startDraw(8'd10, 7'd20);
    checkOutput("busy_k1", busy, 1);
    checkOutput("addr_k1", addr_read, 0);
    waitDone(1, 900, cyc);
    checkOutput("done_cycle", cyc, 841);
    @(negedge clk);
    checkOutput("busy_k842", busy, 0);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("opaque_plots", plot_count, 840);
    checkOutput("opaque_queue", exp_q.size(), 0);
    checkOutput("seen_size", seen_q.size(), 840);
    checkOutput("first_xy", (seen_q.size() > 0)   ? seen_q[0]   : 15'h7fff, {8'd10, 7'd20});
    checkOutput("pix28_xy", (seen_q.size() > 27)  ? seen_q[27]  : 15'h7fff, {8'd37, 7'd20});
    checkOutput("pix29_xy", (seen_q.size() > 28)  ? seen_q[28]  : 15'h7fff, {8'd10, 7'd21});
    checkOutput("last_xy",  (seen_q.size() > 839) ? seen_q[839] : 15'h7fff, {8'd37, 7'd49});

    // Alternating transparency
    clearStats();
    applyStimulus(1, 40, 30);
    startDraw(8'd40, 7'd30);
    waitDone(1, 900, cyc);
    @(negedge clk);
    checkOutput("transp_plots", plot_count, 420);
    checkOutput("transp_queue", exp_q.size(), 0);

    // Clipping at the bottom-right corner
    clearStats();
    applyStimulus(0, 150, 100);
    startDraw(8'd150, 7'd100);
    waitDone(1, 900, cyc);
    @(negedge clk);
    checkOutput("clip_plots", plot_count, 200);
    checkOutput("clip_queue", exp_q.size(), 0);

    // Reset in the middle of a draw, then a clean redraw
    clearStats();
    applyStimulus(0, 5, 5);
    startDraw(8'd5, 7'd5);
    repeat (299) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort_plot", vga_plot, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_addr", addr_read, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    done_count = 0;
    repeat (10) @(negedge clk);
    checkOutput("abort_no_done", done_count, 0);
    clearStats();
    applyStimulus(0, 5, 5);
    startDraw(8'd5, 7'd5);
    checkOutput("redraw_addr", addr_read, 0);
    waitDone(1, 900, cyc);
    checkOutput("redraw_done_cycle", cyc, 841);
    @(negedge clk);
    checkOutput("redraw_plots", plot_count, 840);
    checkOutput("redraw_queue", exp_q.size(), 0);

    // go re-pulsed while busy must be ignored
    clearStats();
    applyStimulus(0, 60, 50);
    startDraw(8'd60, 7'd50);
    repeat (49) @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    waitDone(51, 900, cyc);
    checkOutput("repulse_done_cycle", cyc, 841);
    repeat (5) @(negedge clk);
    checkOutput("repulse_done_count", done_count, 1);
    checkOutput("repulse_busy", busy, 0);
    checkOutput("repulse_plots", plot_count, 840);
    checkOutput("repulse_queue", exp_q.size(), 0);

    // go held high: back-to-back draws with one idle cycle between them
    clearStats();
    applyStimulus(0, 20, 10);
    applyStimulus(0, 20, 10);
    @(negedge clk);
    x_origin = 8'd20;
    y_origin = 7'd10;
    go = 1'b1;
    @(negedge clk);
    waitDone(1, 900, cyc);
    checkOutput("held_done1_cycle", cyc, 841);
    @(negedge clk);
    checkOutput("held_idle_gap", busy, 0);
    @(negedge clk);
    checkOutput("held_restart_busy", busy, 1);
    checkOutput("held_restart_addr", addr_read, 0);
    go = 1'b0;
    waitDone(843, 1800, cyc);
    checkOutput("held_done2_cycle", cyc, 1683);
    @(negedge clk);
    checkOutput("held_done_count", done_count, 2);
    checkOutput("held_plots", plot_count, 1680);
    checkOutput("held_queue", exp_q.size(), 0);
    checkOutput("held_end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
